// File: rtl/dsi_packet_assembler.sv
// Purpose: turns timing-generator packet requests into a DSI byte stream (DI, WC/data, ECC, payload, CRC-16).
// Latency: the first header byte is valid 3 clocks after p_req_i is seen in IDLE; after that, one byte per clock.
// Backpressure: each byte is held until out_ready_i; payload words are fetched just in time, so there are no bubbles.
module dsi_packet_assembler #(
    parameter logic [1:0] g_virtual_channel = 2'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        p_req_i,
    output logic        p_dreq_o,
    input  logic        p_islong_i,
    input  logic [5:0]  p_type_i,
    input  logic [15:0] p_wcount_i,
    input  logic [15:0] p_command_i,
    input  logic [23:0] p_payload_i,
    input  logic        p_last_i,
    output logic        out_hs_req_o,
    output logic [7:0]  out_d_o,
    output logic        out_valid_o,
    input  logic        out_ready_i
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_REQ,
        HDR_LATCH,
        HEADER,
        PAYLOAD,
        CRC
    } state_t;

    typedef struct packed {
        logic [7:0] di;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] ecc;
    } hdr_t;

    state_t      state, state_nxt;
    hdr_t        hdr;
    logic        is_long;
    logic        last;
    logic [1:0]  byte_idx;
    logic [23:0] word;
    logic [15:0] remaining;
    logic [15:0] crc;
    logic        hs_req;

    logic        accept;
    logic        fetch;
    logic        hdr_pulse;
    logic        eop;
    logic [7:0]  di_in;
    logic [15:0] field_in;

    // Hamming-style header ECC; D0 is DI bit 0 and D23 is B2 bit 7.
    function automatic logic [7:0] ecc_calc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return {2'b00, p};
    endfunction

    // Reflected CRC-16 (0x8408): the byte is consumed LSB first.
    function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'h8408;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign di_in    = {g_virtual_channel, p_type_i};
    assign field_in = p_islong_i ? p_wcount_i : p_command_i;
    assign accept   = out_valid_o && out_ready_i;
    assign p_dreq_o = hdr_pulse || fetch;
    assign out_hs_req_o = hs_req;

    // Next-state, output byte selection and fetch strobe.
    always_comb begin
        state_nxt   = state;
        hdr_pulse   = 1'b0;
        fetch       = 1'b0;
        eop         = 1'b0;
        out_valid_o = 1'b0;
        out_d_o     = 8'h00;
        case (state)
            IDLE: begin
                if (p_req_i) state_nxt = HDR_REQ;
            end
            HDR_REQ: begin
                hdr_pulse = 1'b1;
                state_nxt = HDR_LATCH;
            end
            HDR_LATCH: begin
                state_nxt = HEADER;
            end
            HEADER: begin
                out_valid_o = 1'b1;
                case (byte_idx)
                    2'd0:    out_d_o = hdr.di;
                    2'd1:    out_d_o = hdr.b1;
                    2'd2:    out_d_o = hdr.b2;
                    default: out_d_o = hdr.ecc;
                endcase
                if (accept && byte_idx == 2'd3) begin
                    if (!is_long) begin
                        eop = 1'b1;
                    end else if (remaining != 16'd0) begin
                        fetch     = 1'b1;
                        state_nxt = PAYLOAD;
                    end else begin
                        state_nxt = CRC;
                    end
                end
            end
            PAYLOAD: begin
                out_valid_o = 1'b1;
                case (byte_idx)
                    2'd0:    out_d_o = word[23:16];
                    2'd1:    out_d_o = word[15:8];
                    default: out_d_o = word[7:0];
                endcase
                if (accept) begin
                    if (remaining == 16'd1)  state_nxt = CRC;
                    else if (byte_idx == 2'd2) fetch = 1'b1;
                end
            end
            CRC: begin
                out_valid_o = 1'b1;
                out_d_o     = byte_idx[0] ? crc[15:8] : crc[7:0];
                if (accept && byte_idx[0]) eop = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        // A packet flagged last closes the burst even if more requests are pending.
        if (eop) begin
            if (last)         state_nxt = IDLE;
            else if (p_req_i) state_nxt = HDR_REQ;
            else              state_nxt = IDLE;
        end
    end

    // State register plus the header, word, counter and CRC datapath.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            hs_req    <= 1'b0;
            hdr       <= '0;
            is_long   <= 1'b0;
            last      <= 1'b0;
            byte_idx  <= 2'd0;
            word      <= 24'h0;
            remaining <= 16'h0;
            crc       <= 16'hFFFF;
        end else begin
            state <= state_nxt;
            if (state == IDLE) hs_req <= p_req_i;
            if (eop && last)   hs_req <= 1'b0;
            if (fetch)         word   <= p_payload_i;
            case (state)
                HDR_LATCH: begin
                    hdr.di    <= di_in;
                    hdr.b1    <= field_in[7:0];
                    hdr.b2    <= field_in[15:8];
                    hdr.ecc   <= ecc_calc({field_in, di_in});
                    is_long   <= p_islong_i;
                    last      <= p_last_i;
                    remaining <= p_islong_i ? p_wcount_i : 16'd0;
                    byte_idx  <= 2'd0;
                    crc       <= 16'hFFFF;
                end
                HEADER: begin
                    if (accept) byte_idx <= byte_idx + 2'd1;
                end
                PAYLOAD: begin
                    if (accept) begin
                        crc       <= crc_byte(crc, out_d_o);
                        remaining <= remaining - 16'd1;
                        // The CRC phase reuses the index, so it restarts at 0 when the payload ends.
                        if (byte_idx == 2'd2 || remaining == 16'd1) byte_idx <= 2'd0;
                        else                                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                CRC: begin
                    if (accept) byte_idx <= byte_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// Purpose: directed bench for dsi_packet_assembler covering short and long packets, stalls and reset.
// Latency: expectations are byte streams and strobe counts; the exact cycle is checked only where it matters.
// Backpressure: out_ready_i is held high or driven randomly.
module tb_dsi_packet_assembler;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        p_req_i = 1'b0;
    logic        p_dreq_o;
    logic        p_islong_i = 1'b0;
    logic [5:0]  p_type_i = 6'h0;
    logic [15:0] p_wcount_i = 16'h0;
    logic [15:0] p_command_i = 16'h0;
    logic [23:0] p_payload_i;
    logic        p_last_i = 1'b0;
    logic        out_hs_req_o;
    logic [7:0]  out_d_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;

    int total = 0;
    int bad = 0;

    logic [23:0] words [256];
    int          widx = 0;
    logic [7:0]  byte_log [256];
    int          byte_cyc [256];
    int          byte_cnt = 0;
    int          hdr_cnt = 0;
    int          stall_err = 0;
    int          cycle_cnt = 0;
    logic        rnd_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_d = 8'h0;

    dsi_packet_assembler #(.g_virtual_channel(2'd0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .p_req_i(p_req_i), .p_dreq_o(p_dreq_o),
        .p_islong_i(p_islong_i), .p_type_i(p_type_i), .p_wcount_i(p_wcount_i),
        .p_command_i(p_command_i), .p_payload_i(p_payload_i), .p_last_i(p_last_i),
        .out_hs_req_o(out_hs_req_o), .out_d_o(out_d_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    assign p_payload_i = words[widx[7:0]];

    // Timing-generator model: advance to the next payload word after each fetch strobe.
    always @(posedge clk_i) begin
        cycle_cnt <= cycle_cnt + 1;
        if (!rst_i && p_dreq_o && out_valid_o) widx <= widx + 1;
    end

    // Lane model: ready is either always high or random, changed just after each edge.
    always @(posedge clk_i) begin
        #1;
        out_ready_i = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: log accepted bytes, header pulses and any byte that changes while stalled.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (out_valid_o && out_ready_i) begin
                byte_log[byte_cnt[7:0]] = out_d_o;
                byte_cyc[byte_cnt[7:0]] = cycle_cnt;
                byte_cnt = byte_cnt + 1;
            end
            if (p_dreq_o && !out_valid_o) hdr_cnt = hdr_cnt + 1;
            if (prev_stall && (!out_valid_o || out_d_o !== prev_d)) stall_err = stall_err + 1;
            prev_stall = out_valid_o && !out_ready_i;
            prev_d     = out_d_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic logic [7:0] ecc_model(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return {2'b00, p};
    endfunction

    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in ^ {8'h00, b};
        repeat (8) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_bytes(input int target, input int budget);
        int n;
        n = 0;
        while (byte_cnt < target && n < budget) begin
            @(negedge clk_i);
            n++;
        end
    endtask

    // Fire a single-cycle request so that exactly one packet is started.
    task automatic pulse_req();
        tick();
        p_req_i = 1'b1;
        tick();
        p_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        @(negedge clk_i);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
        total++; if (out_hs_req_o !== 1'b0) begin bad++; $display("FAIL reset_hs got=%b exp=0", out_hs_req_o); end
        total++; if (p_dreq_o !== 1'b0) begin bad++; $display("FAIL reset_dreq got=%b exp=0", p_dreq_o); end
        total++; if (out_d_o !== 8'h00) begin bad++; $display("FAIL reset_d got=%h exp=00", out_d_o); end
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_short();
        int base, hb;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h01; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h07;
        base = byte_cnt; hb = hdr_cnt;
        p_islong_i = 1'b0; p_type_i = 6'h01; p_command_i = 16'h0000; p_last_i = 1'b0;
        tick();
        p_req_i = 1'b1;
        @(negedge clk_i);
        total++; if (out_hs_req_o !== 1'b0) begin bad++; $display("FAIL short_hs_before got=%b exp=0", out_hs_req_o); end
        @(negedge clk_i);
        total++; if (out_hs_req_o !== 1'b1) begin bad++; $display("FAIL short_hs_rise got=%b exp=1", out_hs_req_o); end
        p_req_i = 1'b0;
        wait_bytes(base + 4, 50);
        total++; if (byte_cnt - base < 4) begin bad++; $display("FAIL short_timeout got=%0d exp=4", byte_cnt - base); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (byte_log[base + i] !== exp_b[i]) begin bad++; $display("FAIL short_byte%0d got=%h exp=%h", i, byte_log[base + i], exp_b[i]); end
        end
        repeat (4) @(negedge clk_i);
        total++; if (hdr_cnt - hb !== 1) begin bad++; $display("FAIL short_dreq_pulses got=%0d exp=1", hdr_cnt - hb); end
        total++; if (out_hs_req_o !== 1'b0) begin bad++; $display("FAIL short_hs_idle got=%b exp=0", out_hs_req_o); end
    endtask

    task automatic test_short_last();
        int base;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h21; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h12;
        base = byte_cnt;
        p_islong_i = 1'b0; p_type_i = 6'h21; p_command_i = 16'h0000; p_last_i = 1'b1;
        pulse_req();
        wait_bytes(base + 4, 50);
        total++; if (byte_cnt - base < 4) begin bad++; $display("FAIL last_timeout got=%0d exp=4", byte_cnt - base); end
        @(negedge clk_i);
        total++; if (out_hs_req_o !== 1'b0) begin bad++; $display("FAIL last_hs_drop got=%b exp=0", out_hs_req_o); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (byte_log[base + i] !== exp_b[i]) begin bad++; $display("FAIL last_byte%0d got=%h exp=%h", i, byte_log[base + i], exp_b[i]); end
        end
        p_last_i = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_long9();
        int base, w0;
        logic [7:0] exp_b [15];
        exp_b[0] = 8'h3E; exp_b[1] = 8'h09; exp_b[2] = 8'h00; exp_b[3] = 8'h31;
        for (int i = 0; i < 9; i++) exp_b[4 + i] = 8'h31 + 8'(i);
        exp_b[13] = 8'h91; exp_b[14] = 8'h6F;
        base = byte_cnt; w0 = widx;
        words[(w0 + 0) % 256] = 24'h313233;
        words[(w0 + 1) % 256] = 24'h343536;
        words[(w0 + 2) % 256] = 24'h373839;
        p_islong_i = 1'b1; p_type_i = 6'h3E; p_wcount_i = 16'd9; p_last_i = 1'b0;
        pulse_req();
        wait_bytes(base + 15, 100);
        total++; if (byte_cnt - base < 15) begin bad++; $display("FAIL long9_timeout got=%0d exp=15", byte_cnt - base); end
        total++; if (ecc_model(24'h00093E) !== byte_log[base + 3]) begin bad++; $display("FAIL long9_ecc_model got=%h exp=%h", byte_log[base + 3], ecc_model(24'h00093E)); end
        for (int i = 0; i < 15; i++) begin
            total++;
            if (byte_log[base + i] !== exp_b[i]) begin bad++; $display("FAIL long9_byte%0d got=%h exp=%h", i, byte_log[base + i], exp_b[i]); end
        end
        total++; if (widx - w0 !== 3) begin bad++; $display("FAIL long9_fetches got=%0d exp=3", widx - w0); end
        total++; if (byte_cyc[base + 14] - byte_cyc[base] !== 14) begin bad++; $display("FAIL long9_span got=%0d exp=14", byte_cyc[base + 14] - byte_cyc[base]); end
        repeat (4) tick();
    endtask

    task automatic test_long_empty();
        int base, w0;
        logic [7:0] exp_b [6];
        logic [7:0] e;
        e = ecc_model(24'h000029);
        exp_b[0] = 8'h29; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = e;
        exp_b[4] = 8'hFF; exp_b[5] = 8'hFF;
        base = byte_cnt; w0 = widx;
        p_islong_i = 1'b1; p_type_i = 6'h29; p_wcount_i = 16'd0; p_last_i = 1'b0;
        pulse_req();
        wait_bytes(base + 6, 60);
        total++; if (byte_cnt - base < 6) begin bad++; $display("FAIL wc0_timeout got=%0d exp=6", byte_cnt - base); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (byte_log[base + i] !== exp_b[i]) begin bad++; $display("FAIL wc0_byte%0d got=%h exp=%h", i, byte_log[base + i], exp_b[i]); end
        end
        total++; if (widx !== w0) begin bad++; $display("FAIL wc0_fetches got=%0d exp=0", widx - w0); end
        repeat (4) tick();
    endtask

    task automatic test_stall();
        int base, w0, se;
        logic [7:0] exp_b [10];
        logic [15:0] c;
        logic [7:0] e;
        e = ecc_model(24'h000429);
        exp_b[0] = 8'h29; exp_b[1] = 8'h04; exp_b[2] = 8'h00; exp_b[3] = e;
        exp_b[4] = 8'hA1; exp_b[5] = 8'hB2; exp_b[6] = 8'hC3; exp_b[7] = 8'hD4;
        c = 16'hFFFF;
        for (int i = 4; i < 8; i++) c = crc_model(c, exp_b[i]);
        exp_b[8] = c[7:0]; exp_b[9] = c[15:8];
        base = byte_cnt; w0 = widx; se = stall_err;
        words[(w0 + 0) % 256] = 24'hA1B2C3;
        words[(w0 + 1) % 256] = 24'hD4E5F6;
        words[(w0 + 2) % 256] = 24'hDEAD00;
        p_islong_i = 1'b1; p_type_i = 6'h29; p_wcount_i = 16'd4; p_last_i = 1'b0;
        rnd_en = 1'b1;
        pulse_req();
        wait_bytes(base + 10, 400);
        rnd_en = 1'b0;
        total++; if (byte_cnt - base < 10) begin bad++; $display("FAIL stall_timeout got=%0d exp=10", byte_cnt - base); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (byte_log[base + i] !== exp_b[i]) begin bad++; $display("FAIL stall_byte%0d got=%h exp=%h", i, byte_log[base + i], exp_b[i]); end
        end
        total++; if (widx - w0 !== 2) begin bad++; $display("FAIL stall_fetches got=%0d exp=2", widx - w0); end
        total++; if (stall_err - se !== 0) begin bad++; $display("FAIL stall_hold got=%0d exp=0", stall_err - se); end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        int base;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h01; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h07;
        base = byte_cnt;
        words[widx % 256]       = 24'h111111;
        words[(widx + 1) % 256] = 24'h222222;
        words[(widx + 2) % 256] = 24'h333333;
        p_islong_i = 1'b1; p_type_i = 6'h3E; p_wcount_i = 16'd9; p_last_i = 1'b0;
        pulse_req();
        wait_bytes(base + 6, 60);
        total++; if (byte_cnt - base < 6) begin bad++; $display("FAIL rstmid_timeout got=%0d exp=6", byte_cnt - base); end
        tick();
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid_o); end
        total++; if (out_hs_req_o !== 1'b0) begin bad++; $display("FAIL rstmid_hs got=%b exp=0", out_hs_req_o); end
        total++; if (p_dreq_o !== 1'b0) begin bad++; $display("FAIL rstmid_dreq got=%b exp=0", p_dreq_o); end
        tick();
        rst_i = 1'b0;
        base = byte_cnt;
        p_islong_i = 1'b0; p_type_i = 6'h01; p_command_i = 16'h0000; p_last_i = 1'b1;
        pulse_req();
        wait_bytes(base + 4, 50);
        total++; if (byte_cnt - base !== 4) begin bad++; $display("FAIL rstmid_count got=%0d exp=4", byte_cnt - base); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (byte_log[base + i] !== exp_b[i]) begin bad++; $display("FAIL rstmid_byte%0d got=%h exp=%h", i, byte_log[base + i], exp_b[i]); end
        end
        repeat (3) tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) words[i] = 24'h0;
        test_reset();
        test_short();
        test_short_last();
        test_long9();
        test_long_empty();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
